// File: rtl/field_sweep_ctrl_pkg.sv
// Shared types for the Game of Life generation sweep: field select, sweep mode and controller state.
package field_sweep_ctrl_pkg;

    localparam int NEIGHBOURS_CNT = 8;

    typedef enum logic {
        FIELD_A = 1'b0,
        FIELD_B = 1'b1
    } field_t;

    typedef enum logic {
        MODE_STEP = 1'b0,
        MODE_RUN  = 1'b1
    } sweep_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        GAP   = 2'd2
    } sweep_state_t;

    function automatic int adr_size(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/next_cell_state.sv
// B3/S23 rule for a single cell given its current state and its eight neighbours.
module next_cell_state
    import field_sweep_ctrl_pkg::*;
(
    input  logic                      i_cell,
    input  logic [NEIGHBOURS_CNT-1:0] i_nbrs,
    output logic                      o_next
);

    logic [3:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int unsigned i = 0; i < NEIGHBOURS_CNT; i++) begin
            w_cnt = w_cnt + {3'b000, i_nbrs[i]};
        end
        o_next = (w_cnt == 4'd3) || (i_cell && (w_cnt == 4'd2));
    end

endmodule

// File: rtl/sweep_addr_gen.sv
// Row-major lane-group coordinate stepper: holds the read pointer and the registered
// write coordinate one group behind it, flagging when the write side sits on the last group.
module sweep_addr_gen
    import field_sweep_ctrl_pkg::*;
#(
    parameter int FIELD_W    = 4,
    parameter int FIELD_H    = 4,
    parameter int LANES      = 1,
    parameter int X_ADR_SIZE = adr_size(FIELD_W),
    parameter int Y_ADR_SIZE = adr_size(FIELD_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_advance,
    output logic [X_ADR_SIZE-1:0] o_rd_x,
    output logic [Y_ADR_SIZE-1:0] o_rd_y,
    output logic [X_ADR_SIZE-1:0] o_cur_x,
    output logic [Y_ADR_SIZE-1:0] o_cur_y,
    output logic                  o_cur_last
);

    localparam int X_MAX = FIELD_W - LANES;
    localparam int Y_MAX = FIELD_H - 1;
    localparam logic [X_ADR_SIZE-1:0] X_LAST = X_ADR_SIZE'(X_MAX);
    localparam logic [Y_ADR_SIZE-1:0] Y_LAST = Y_ADR_SIZE'(Y_MAX);
    localparam logic [X_ADR_SIZE-1:0] X_STEP = X_ADR_SIZE'(LANES);
    localparam logic [Y_ADR_SIZE-1:0] Y_ONE  = Y_ADR_SIZE'(1);

    logic [X_ADR_SIZE-1:0] r_rd_x, r_cur_x, w_step_x;
    logic [Y_ADR_SIZE-1:0] r_rd_y, r_cur_y, w_step_y;

    always_comb begin
        w_step_x = r_rd_x + X_STEP;
        w_step_y = r_rd_y;
        if (r_rd_x == X_LAST) begin
            w_step_x = '0;
            w_step_y = (r_rd_y == Y_LAST) ? '0 : r_rd_y + Y_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_x  <= '0;
            r_rd_y  <= '0;
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            r_cur_x <= r_rd_x;
            r_cur_y <= r_rd_y;
            if (i_advance) begin
                r_rd_x <= w_step_x;
                r_rd_y <= w_step_y;
            end
        end
    end

    assign o_rd_x     = r_rd_x;
    assign o_rd_y     = r_rd_y;
    assign o_cur_x    = r_cur_x;
    assign o_cur_y    = r_cur_y;
    assign o_cur_last = (r_cur_x == X_LAST) && (r_cur_y == Y_LAST);

endmodule

// File: rtl/field_sweep_ctrl.sv
// Generation sweep controller: walks the field LANES cells per cycle, applies the life rule,
// flips the ping-pong read field per generation and sequences STEP/RUN operation.
module field_sweep_ctrl
    import field_sweep_ctrl_pkg::*;
#(
    parameter int FIELD_W   = 4,
    parameter int FIELD_H   = 4,
    parameter int LANES     = 1,
    parameter int GEN_CNT_W = 16,
    localparam int X_ADR_SIZE = adr_size(FIELD_W),
    localparam int Y_ADR_SIZE = adr_size(FIELD_H),
    localparam int ALIVE_W    = $clog2(FIELD_W * FIELD_H + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_go,
    input  sweep_mode_t                     i_mode,
    input  logic                            i_stop,
    input  logic [GEN_CNT_W-1:0]            i_gen_limit,
    input  logic [LANES-1:0]                i_next_cell_states,
    input  logic [LANES*NEIGHBOURS_CNT-1:0] i_next_nbrs,
    output logic                            o_busy,
    output logic                            o_wr_en,
    output logic [X_ADR_SIZE-1:0]           o_cur_x,
    output logic [Y_ADR_SIZE-1:0]           o_cur_y,
    output logic [X_ADR_SIZE-1:0]           o_next_x,
    output logic [Y_ADR_SIZE-1:0]           o_next_y,
    output logic [LANES-1:0]                o_new_cells,
    output field_t                          o_cur_read_field,
    output logic [GEN_CNT_W-1:0]            o_gen_cnt,
    output logic [ALIVE_W-1:0]              o_alive_cnt,
    output logic                            o_gen_done
);

    sweep_state_t                    r_state;
    sweep_mode_t                     r_mode;
    logic [GEN_CNT_W-1:0]            r_limit;
    logic [GEN_CNT_W-1:0]            r_run_cnt;
    logic [GEN_CNT_W-1:0]            r_gen_cnt;
    logic                            r_stop_seen;
    field_t                          r_read_field;
    logic [ALIVE_W-1:0]              r_alive_acc;
    logic [ALIVE_W-1:0]              r_alive_cnt;
    logic                            r_gen_done;
    logic [LANES-1:0]                r_cells;
    logic [LANES*NEIGHBOURS_CNT-1:0] r_nbrs;

    logic                            w_advance;
    logic                            w_cur_last;
    logic                            w_continue;
    logic [LANES-1:0]                w_new_cells;
    logic [ALIVE_W-1:0]              w_acc_next;
    logic [GEN_CNT_W:0]              w_run_inc;

    function automatic logic [ALIVE_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [ALIVE_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            s = s + ALIVE_W'(v[i]);
        end
        return s;
    endfunction

    // The read pointer holds at (0,0) once the last group is issued, so GAP re-reads
    // the origin on the freshly flipped field.
    assign w_advance = ((r_state == IDLE) && i_go)
                     || ((r_state == SWEEP) && !w_cur_last)
                     || (r_state == GAP);

    sweep_addr_gen #(
        .FIELD_W    (FIELD_W),
        .FIELD_H    (FIELD_H),
        .LANES      (LANES),
        .X_ADR_SIZE (X_ADR_SIZE),
        .Y_ADR_SIZE (Y_ADR_SIZE)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (w_advance),
        .o_rd_x     (o_next_x),
        .o_rd_y     (o_next_y),
        .o_cur_x    (o_cur_x),
        .o_cur_y    (o_cur_y),
        .o_cur_last (w_cur_last)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        next_cell_state u_ncs (
            .i_cell (r_cells[k]),
            .i_nbrs (r_nbrs[k*NEIGHBOURS_CNT +: NEIGHBOURS_CNT]),
            .o_next (w_new_cells[k])
        );
    end

    assign w_acc_next = r_alive_acc + popcount(w_new_cells);
    assign w_run_inc  = {1'b0, r_run_cnt} + (GEN_CNT_W + 1)'(1);
    assign w_continue = (r_mode == MODE_RUN) && !r_stop_seen && !i_stop
                      && ((r_limit == '0) || (w_run_inc < {1'b0, r_limit}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mode       <= MODE_STEP;
            r_limit      <= '0;
            r_run_cnt    <= '0;
            r_gen_cnt    <= '0;
            r_stop_seen  <= 1'b0;
            r_read_field <= FIELD_A;
            r_alive_acc  <= '0;
            r_alive_cnt  <= '0;
            r_gen_done   <= 1'b0;
            r_cells      <= '0;
            r_nbrs       <= '0;
        end else begin
            r_cells    <= i_next_cell_states;
            r_nbrs     <= i_next_nbrs;
            r_gen_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_go) begin
                        r_mode      <= i_stop ? MODE_STEP : i_mode;
                        r_limit     <= i_gen_limit;
                        r_run_cnt   <= '0;
                        r_alive_acc <= '0;
                        r_stop_seen <= 1'b0;
                        r_state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    r_alive_acc <= w_acc_next;
                    if (i_stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (w_cur_last) begin
                        r_read_field <= (r_read_field == FIELD_A) ? FIELD_B : FIELD_A;
                        r_gen_cnt    <= r_gen_cnt + GEN_CNT_W'(1);
                        r_run_cnt    <= r_run_cnt + GEN_CNT_W'(1);
                        r_alive_cnt  <= w_acc_next;
                        r_gen_done   <= 1'b1;
                        if (w_continue) begin
                            r_state <= GAP;
                        end else begin
                            r_state     <= IDLE;
                            r_stop_seen <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    r_alive_acc <= '0;
                    if (i_stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    r_state <= SWEEP;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy           = (r_state == SWEEP) || (r_state == GAP);
    assign o_wr_en          = (r_state == SWEEP);
    assign o_new_cells      = w_new_cells;
    assign o_cur_read_field = r_read_field;
    assign o_gen_cnt        = r_gen_cnt;
    assign o_alive_cnt      = r_alive_cnt;
    assign o_gen_done       = r_gen_done;

endmodule

// File: doc/field_sweep_ctrl.md
# field_sweep_ctrl

Generation sweep controller for the Game of Life core. It walks the field in row-major order, LANES cells per cycle, and computes each cell's next state from the neighbour data supplied by the field memory. It drives the ping-pong field select, and supports single-step and free-running modes with a generation limit and a graceful stop. It sits between the control/UI logic and the dual field memories, and replaces the single-lane, single-generation sweep iterator.

## Interface
Parameters:
- FIELD_W, none, field width in cells; must be a multiple of LANES.
- FIELD_H, none, field height in cells.
- LANES, 1, cells processed per cycle (1, 2, 4, ...).
- GEN_CNT_W, 16, width of the generation counter and generation limit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_go  in  1  start request, sampled in IDLE only.
- i_mode  in  sweep_mode_t  MODE_STEP or MODE_RUN, sampled with i_go.
- i_stop  in  1  in RUN, finish the current generation, then go IDLE.
- i_gen_limit  in  GEN_CNT_W  RUN generation budget per start; 0 = unlimited.
- i_next_cell_states  in  LANES  current states of the cells at o_next_x..+LANES-1, o_next_y.
- i_next_nbrs  in  LANES×NEIGHBOURS_CNT  neighbours of those cells.
- o_busy  out  1  state is SWEEP or GAP.
- o_wr_en  out  1  o_new_cells is valid for o_cur_x/o_cur_y this cycle (state == SWEEP).
- o_cur_x / o_cur_y  out  X_ADR_SIZE / Y_ADR_SIZE  lane-0 coordinate being written.
- o_next_x / o_next_y  out  X_ADR_SIZE / Y_ADR_SIZE  lane-0 coordinate to read this cycle; combinational from next state.
- o_new_cells  out  LANES  next-generation states; lane k is at x+k.
- o_cur_read_field  out  field_t  field being read; the write field is its complement.
- o_gen_cnt  out  GEN_CNT_W  completed generations since reset; wraps.
- o_alive_cnt  out  $clog2(FIELD_W*FIELD_H+1)  live cells in the last completed generation.
- o_gen_done  out  1  one-cycle pulse after each generation completes.

## Operation
- States: IDLE, SWEEP, GAP.
- **IDLE**
  - Coordinates held at 0.
  - i_go=1 latches mode and limit, clears the per-run generation count and alive accumulator, and moves to SWEEP.
  - i_go together with i_stop forces MODE_STEP.
- **SWEEP**
  - Each cycle: o_wr_en=1, and the alive accumulator adds popcount(o_new_cells).
  - x advances by LANES. At x = FIELD_W-LANES, x goes to 0 and y increments.
- **Last group** (x = FIELD_W-LANES, y = FIELD_H-1):
  - read_field flips, o_gen_cnt increments and wraps, and o_alive_cnt takes the final accumulated value.
  - o_gen_done pulses on the following cycle.
  - Next state is GAP if all of these hold: mode is RUN, i_stop is not seen during the generation, and either the limit is 0 or the run count + 1 < limit. Otherwise the next state is IDLE.
- **GAP**
  - One cycle with o_wr_en=0 and o_next = (0,0) on the new read field, so that the last-row writes land before the wrap-around neighbours of (0,0) are read.
  - Clears the accumulator, then moves to SWEEP.
- **i_stop**
  - Sticky once seen in SWEEP or GAP.
  - Cleared on entry to IDLE.
  - Ignored in IDLE unless asserted together with i_go.
- Each lane uses next_cell_state (B3/S23); lanes are independent.

## Timing
- Reset values:
  - o_busy=0, o_wr_en=0.
  - All coordinates 0.
  - o_new_cells=0 (registered inputs are cleared).
  - o_cur_read_field=FIELD_A.
  - o_gen_cnt=0, o_alive_cnt=0, o_gen_done=0.
- Read path: the memory answers o_next_* combinationally. Inputs are registered at the edge; o_new_cells for that group is valid in the next cycle.
- Latency:
  - i_go at edge N gives the first o_wr_en in cycle N+1.
  - One generation lasts FIELD_W*FIELD_H/LANES SWEEP cycles.
  - Back-to-back generations in RUN are separated by exactly one GAP cycle.
- Reset mid-sweep: asynchronous return to the reset values. The partially written field is abandoned and read_field returns to FIELD_A.
- Width rules:
  - Coordinate compares use X_MAX/Y_MAX cast to the address widths.
  - The alive accumulator is sized to hold FIELD_W*FIELD_H without overflow.

## Structure
- Package defs:
  - Existing: field_t, FIELD_A/FIELD_B, NEIGHBOURS_CNT.
  - Add: sweep_mode_t {MODE_STEP, MODE_RUN} and sweep_state_t {IDLE, SWEEP, GAP}.
- Sub-module sweep_addr_gen: lane-group coordinate stepping with an end-of-field flag, parameterised by FIELD_W, FIELD_H and LANES.
- next_cell_state is instantiated LANES times via generate.
- Popcount and control are kept in the top module.

## Test plan
- W=H=4, LANES=1, STEP, pulse i_go:
  - 16 cycles with o_wr_en=1 and coordinates (0,0)…(3,3).
  - Then o_busy=0, read_field=FIELD_B, o_gen_cnt=1, one o_gen_done pulse.
- Horizontal blinker at row 2, cols 1–3, on 5×5 LANES=1: o_new_cells is high only at (2,1), (2,2), (2,3); o_alive_cnt=3.
- W=8, H=2, LANES=2, STEP:
  - Exactly 8 o_wr_en cycles; o_cur_x steps 0,2,4,6.
  - Lane 1 result matches the reference model at x+1.
- RUN with i_gen_limit=3:
  - Three 16-cycle sweeps, each separated by one GAP cycle (o_wr_en=0, o_next=(0,0)).
  - o_gen_cnt ends at 3; read_field ends at FIELD_B; then IDLE.
- RUN with limit 0, i_stop pulsed mid-second generation: the second generation completes, then IDLE with o_gen_cnt=2. Separately, i_go+i_stop together runs exactly one generation.
- rst asserted at cycle 7 of a sweep: all outputs go to their reset values immediately; a new i_go restarts at (0,0) reading FIELD_A.
